// File: rtl/mod461_pkg.sv
// mod461_pkg: shared constants, types and arithmetic helpers for the mod-461
// chunked reducer.
//   MODULUS/RES_W/CHUNK_W/MAX_CHUNKS - arithmetic geometry
//   WEIGHT[k]                        - 2^(6k) mod 461, the positional weight of chunk k
//   state_e                          - controller states
//   reduce_prod()                    - reduce a chunk*weight product into 0..460
//   add_mod()                        - modular add of two residues
package mod461_pkg;

  localparam int MODULUS    = 461;
  localparam int RES_W      = 9;
  localparam int CHUNK_W    = 6;
  localparam int MAX_CHUNKS = 8;
  localparam int PROD_W     = CHUNK_W + RES_W;

  localparam logic [RES_W-1:0] WEIGHT [0:MAX_CHUNKS-1] = '{
    9'd1, 9'd64, 9'd408, 9'd296, 9'd43, 9'd447, 9'd26, 9'd281
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A product of a 6-bit chunk and a weight (<= 460) is below 461*64, so a
  // restoring reduction over the shifts 461<<6 .. 461<<0 always lands in 0..460.
  function automatic logic [RES_W-1:0] reduce_prod(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] rem;
    rem = prod;
    for (int j = 6; j >= 0; j--) begin
      if (rem >= (PROD_W'(MODULUS) << j)) begin
        rem = rem - (PROD_W'(MODULUS) << j);
      end else begin
        rem = rem;
      end
    end
    return rem[RES_W-1:0];
  endfunction

  // Both operands are residues (<= 460), so one conditional subtract suffices.
  function automatic logic [RES_W-1:0] add_mod(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 10'(MODULUS)) begin
      sum = sum - 10'(MODULUS);
    end else begin
      sum = sum;
    end
    return sum[RES_W-1:0];
  endfunction

endpackage

// File: rtl/mod461_chunk_lut.sv
// mod461_chunk_lut: combinational residue lookup for one 6-bit chunk.
//   chunk [5:0] in  - chunk value
//   k     [2:0] in  - chunk position within the operand
//   term  [8:0] out - (chunk * 2^(6k)) mod 461
module mod461_chunk_lut
  import mod461_pkg::*;
(
  input  logic [CHUNK_W-1:0] chunk,
  input  logic [2:0]         k,
  output logic [RES_W-1:0]   term
);

  logic [PROD_W-1:0] prod_s;

  // Weighted product followed by constant-divisor reduction.
  always_comb begin
    prod_s = PROD_W'(chunk) * PROD_W'(WEIGHT[k]);
    term   = reduce_prod(prod_s);
  end

endmodule

// File: rtl/mod461_seq_reducer.sv
// mod461_seq_reducer: reduces a 6*N_CHUNKS-bit unsigned operand modulo 461,
// one chunk per clock, with valid/ready handshakes on both sides.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (in_ready is combinational)
//   in_data             - operand, sampled only on acceptance
//   out_valid/out_ready - result handshake
//   out_res [8:0]       - in_data mod 461, held until the result is taken
//   busy                - high while an operand is in flight (RUN or DONE)
// N_CHUNKS must lie in 1..8.
module mod461_seq_reducer
  import mod461_pkg::*;
#(
  parameter int N_CHUNKS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHUNK_W*N_CHUNKS-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RES_W-1:0]             out_res,
  output logic                         busy
);

  localparam int         OP_W     = CHUNK_W * N_CHUNKS;
  localparam logic [2:0] LAST_IDX = 3'(N_CHUNKS - 1);

  state_e              state_r;
  state_e              state_s;
  logic [2:0]          idx_r;
  logic [OP_W-1:0]     op_r;
  logic [RES_W-1:0]    acc_r;
  logic [CHUNK_W-1:0]  chunk_s;
  logic [RES_W-1:0]    term_s;
  logic                in_ready_s;
  logic                accept_s;

  mod461_chunk_lut u_lut (
    .chunk (chunk_s),
    .k     (idx_r),
    .term  (term_s)
  );

  // Select the chunk addressed by idx_r from the latched operand.
  always_comb begin
    chunk_s = {CHUNK_W{1'b0}};
    for (int k = 0; k < N_CHUNKS; k++) begin
      chunk_s = (idx_r == 3'(k)) ? op_r[CHUNK_W*k +: CHUNK_W] : chunk_s;
    end
  end

  // Acceptance is possible when idle, or in DONE when the result leaves this edge.
  always_comb begin
    in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = RUN;
        end else if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, chunk index and modular accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= {OP_W{1'b0}};
      idx_r <= 3'd0;
      acc_r <= {RES_W{1'b0}};
    end else if (accept_s) begin
      op_r  <= in_data;
      idx_r <= 3'd0;
      acc_r <= {RES_W{1'b0}};
    end else if (state_r == RUN) begin
      acc_r <= add_mod(acc_r, term_s);
      idx_r <= idx_r + 3'd1;
    end else begin
      op_r  <= op_r;
      idx_r <= idx_r;
      acc_r <= acc_r;
    end
  end

  // Outputs are decodes of registered state; in_ready alone depends on out_ready.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = (state_r == DONE);
    busy      = (state_r != IDLE);
    out_res   = acc_r;
  end

endmodule

// File: tb/tb_mod461_seq_reducer.sv
// Scoreboard bench for mod461_seq_reducer (N_CHUNKS = 8, 48-bit operands).
// The driver pushes expected residues on acceptance and status probes for
// the coming cycle; a monitor consumes both on the falling clock edge.
module tb_mod461_seq_reducer;

  localparam int N_RAND = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = 48'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_res;
  logic        busy;

  typedef struct {
    int         kind;    // 0 status, 1 value, 2 timeout, 3 handshake gap
    string      name;
    int         act;
    int         exp;
    logic       e_ir;
    logic       e_ov;
    logic       e_busy;
    logic       chk_res;
    logic [8:0] e_res;
  } probe_t;

  logic [8:0] exp_q[$];
  probe_t     probe_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = 0;
  int prev_hs = 0;
  bit accepted = 1'b0;

  mod461_seq_reducer #(.N_CHUNKS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: evaluates queued probes and scores every output handshake.
  initial begin
    probe_t p;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      while (probe_q.size() != 0) begin
        p = probe_q.pop_front();
        n_vec++;
        case (p.kind)
          0: begin
            if ({in_ready, out_valid, busy} !== {p.e_ir, p.e_ov, p.e_busy} ||
                (p.chk_res && (out_res !== p.e_res))) begin
              n_err++;
              $display("FAIL %s: got ir/ov/busy=%b%b%b res=%0d, want %b%b%b res=%0d (cycle %0d)",
                       p.name, in_ready, out_valid, busy, out_res,
                       p.e_ir, p.e_ov, p.e_busy, p.e_res, cyc);
            end
          end
          1: begin
            if (p.act != p.exp) begin
              n_err++;
              $display("FAIL %s: got %0d, want %0d", p.name, p.act, p.exp);
            end
          end
          3: begin
            if ((last_hs - prev_hs) != p.exp) begin
              n_err++;
              $display("FAIL %s: got gap %0d, want %0d", p.name, last_hs - prev_hs, p.exp);
            end
          end
          default: begin
            n_err++;
            $display("FAIL %s: timed out waiting for the DUT", p.name);
          end
        endcase
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got res=%0d, want no output (cycle %0d)", out_res, cyc);
        end else begin
          e = exp_q.pop_front();
          if (out_res !== e) begin
            n_err++;
            $display("FAIL residue: got %0d, want %0d (cycle %0d)", out_res, e, cyc);
          end
        end
        prev_hs = last_hs;
        last_hs = cyc;
      end
    end
  end

  task automatic push_status(input string name, input logic ir, input logic ov,
                             input logic bz, input logic chk, input logic [8:0] res);
    probe_t p;
    p.kind = 0; p.name = name; p.act = 0; p.exp = 0;
    p.e_ir = ir; p.e_ov = ov; p.e_busy = bz; p.chk_res = chk; p.e_res = res;
    probe_q.push_back(p);
  endtask

  task automatic push_other(input int kind, input string name, input int act, input int exp);
    probe_t p;
    p.kind = kind; p.name = name; p.act = act; p.exp = exp;
    p.e_ir = 1'b0; p.e_ov = 1'b0; p.e_busy = 1'b0; p.chk_res = 1'b0; p.e_res = 9'd0;
    probe_q.push_back(p);
  endtask

  // One clock: sample acceptance before the edge, return just after it.
  task automatic step();
    @(negedge clk);
    accepted = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [47:0] op, input logic [8:0] exp, input bit push);
    int n = 0;
    in_data  = op;
    in_valid = 1'b1;
    step();
    while (!accepted && n < 50) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    in_data  = 48'hA5A5_5A5A_C3C3;
    if (accepted) begin
      if (push) exp_q.push_back(exp);
    end else begin
      push_other(2, "offer_accept", 0, 0);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      push_other(2, name, 0, 0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    logic [47:0] op;
    int sent;
    int gap;
    int guard;
    int n;

    // Reset values, checked while rst_n is still low.
    push_status("reset_state", 1'b1, 1'b0, 1'b0, 1'b1, 9'd0);
    step();
    step();
    rst_n = 1'b1;
    push_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 9'd0);
    step();

    // Zero operand: latency of exactly 8 cycles, busy throughout.
    out_ready = 1'b0;
    offer(48'd0, 9'd0, 1'b1);
    for (int j = 0; j <= 8; j++) begin
      push_status("latency", 1'b0, (j == 8), 1'b1, (j == 8), 9'd0);
      step();
    end
    out_ready = 1'b1;
    wait_done("zero_done");

    // Small and edge operands.
    offer(48'd461, 9'd0, 1'b1);               wait_done("op_461");
    offer(48'd460, 9'd460, 1'b1);             wait_done("op_460");
    offer(48'd1000, 9'd78, 1'b1);             wait_done("op_1000");
    offer(48'hFFFF_FFFF_FFFF, 9'd4, 1'b1);    wait_done("op_all_ones");
    offer(48'd921, 9'd460, 1'b1);             wait_done("op_921");

    // Back-to-back: second operand accepted on the first result's handshake.
    out_ready = 1'b1;
    in_data   = 48'd1000;
    in_valid  = 1'b1;
    step();
    if (accepted) exp_q.push_back(9'd78);
    else push_other(2, "b2b_first_accept", 0, 0);
    in_data = 48'd461;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 40);
    exp_q.push_back(9'd0);
    in_valid = 1'b0;
    in_data  = 48'd7;
    push_other(1, "b2b_accept_gap", n, 9);
    wait_done("b2b_done");
    push_other(3, "b2b_result_gap", 0, 9);
    step();

    // Backpressure: result held for 20 cycles with in_ready low.
    out_ready = 1'b0;
    offer(48'd1000, 9'd78, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    for (int j = 0; j < 20; j++) begin
      push_status("bp_hold", 1'b0, 1'b1, 1'b1, 1'b1, 9'd78);
      step();
    end
    out_ready = 1'b1;
    step();
    push_status("bp_release", 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step();

    // Reset after E3: everything returns to reset values at once, no output.
    offer(48'd12345, 9'd0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    push_status("rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 9'd0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      push_status("rst_no_output", 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
      step();
    end
    offer(48'h8000_0000_0000, 9'd233, 1'b1);
    wait_done("op_2p47");

    // Random operands with random input gaps and output stalls.
    sent  = 0;
    guard = 0;
    gap   = $urandom_range(0, 2);
    op    = 48'd0;
    while (sent < N_RAND && guard < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid) begin
        if (gap == 0) begin
          op       = {16'($urandom()), $urandom()};
          in_data  = op;
          in_valid = 1'b1;
        end else begin
          gap--;
        end
      end
      step();
      if (accepted) begin
        exp_q.push_back(9'(op % 48'd461));
        in_valid = 1'b0;
        in_data  = {$urandom(), 16'hDEAD};
        sent++;
        gap = $urandom_range(0, 2);
      end
      guard++;
    end
    out_ready = 1'b1;
    wait_done("rand_drain");
    push_other(1, "rand_sent", sent, N_RAND);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
